// File: rtl/lc3b_types.sv
// Shared LC-3b types: data word, write lane mask and memory operation kind.
package lc3b_types;

   typedef logic [15:0] lc3b_word;
   typedef logic [1:0]  lc3b_mem_wmask;

   typedef enum logic {
      mop_read  = 1'b0,
      mop_write = 1'b1
   } lc3b_mem_op;

endpackage

// File: rtl/byte_en_ram.sv
// Word-wide RAM with per-byte write enables and a registered read port.
// Ports:
//   clk      rising-edge clock
//   rst      async active-high reset (read register only; array is not reset)
//   idx_i    word index
//   we_i     lane write enables, [1]=high byte, [0]=low byte
//   re_i     load read register from idx_i on this edge
//   wdata_i  write data
//   rdata_o  registered read data
module byte_en_ram
   import lc3b_types::*;
#(
   parameter int unsigned IDX_WIDTH = 15,
   parameter              INIT_FILE = ""
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [IDX_WIDTH-1:0] idx_i,
   input  lc3b_mem_wmask        we_i,
   input  logic                 re_i,
   input  lc3b_word             wdata_i,
   output lc3b_word             rdata_o
);

   localparam int unsigned DEPTH = 1 << IDX_WIDTH;

   lc3b_word mem_q [DEPTH];
   lc3b_word rdata_q;

   // Lane-masked write.
   always_ff @(posedge clk) begin
      if (we_i[0]) mem_q[idx_i][7:0]  <= wdata_i[7:0];
      if (we_i[1]) mem_q[idx_i][15:8] <= wdata_i[15:8];
   end

   // Read register holds its value until the next read.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)       rdata_q <= '0;
      else if (re_i) rdata_q <= mem_q[idx_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the LC-3b memory interface: accepts level-held
// read/write requests and answers with a one-cycle mem_resp after a fixed
// number of wait states, backed by a byte-enabled word RAM.
// Ports:
//   clk              rising-edge clock
//   rst              async active-high reset
//   mem_address      byte address (bit 0 ignored)
//   mem_read         read request, held until mem_resp
//   mem_write        write request, held until mem_resp
//   mem_byte_enable  write lane mask, [1]=high byte, [0]=low byte
//   mem_wdata        write data
//   mem_rdata        read data, updated when a read completes
//   mem_resp         one-cycle completion pulse
//   proto_err        sticky protocol-violation flag
module mem_responder
   import lc3b_types::*;
#(
   parameter int unsigned ADDR_WIDTH = 16,
   parameter int unsigned READ_WAIT  = 2,
   parameter int unsigned WRITE_WAIT = 2,
   parameter              INIT_FILE  = ""
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] mem_address,
   input  logic                  mem_read,
   input  logic                  mem_write,
   input  lc3b_mem_wmask         mem_byte_enable,
   input  lc3b_word              mem_wdata,
   output lc3b_word              mem_rdata,
   output logic                  mem_resp,
   output logic                  proto_err
);

   localparam int unsigned IDX_W = ADDR_WIDTH - 1;
   localparam int unsigned CNT_W = 4;
   localparam logic [CNT_W-1:0] RD_WAIT = CNT_W'(READ_WAIT);
   localparam logic [CNT_W-1:0] WR_WAIT = CNT_W'(WRITE_WAIT);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_RESP,
      ST_TURN
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic [IDX_W-1:0] idx_q,   idx_d;
   lc3b_mem_op       op_q,    op_d;
   lc3b_mem_wmask    mask_q,  mask_d;
   lc3b_word         wdata_q, wdata_d;
   logic             resp_q,  resp_d;
   logic             err_q,   err_d;

   logic             req_c;
   logic             commit_c;
   lc3b_mem_op       cmt_op_c;
   lc3b_mem_wmask    cmt_mask_c;
   logic [IDX_W-1:0] ram_idx_c;
   lc3b_word         ram_wdata_c;
   lc3b_mem_wmask    ram_we_c;
   logic             ram_re_c;

   // Byte-address LSB selects nothing in a word-wide RAM.
   logic addr_lsb_unused;
   assign addr_lsb_unused = mem_address[0];

   // Next-state, capture and RAM-commit logic.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      op_d     = op_q;
      mask_d   = mask_q;
      wdata_d  = wdata_q;
      err_d    = err_q;
      commit_c = 1'b0;
      req_c    = mem_read | mem_write;

      // A zero-wait commit happens on the capture edge, so it must use the
      // live request; every later commit uses the captured copy.
      if (state_q == ST_IDLE) begin
         cmt_op_c    = mem_write ? mop_write : mop_read;
         cmt_mask_c  = mem_byte_enable;
         ram_idx_c   = mem_address[ADDR_WIDTH-1:1];
         ram_wdata_c = mem_wdata;
      end else begin
         cmt_op_c    = op_q;
         cmt_mask_c  = mask_q;
         ram_idx_c   = idx_q;
         ram_wdata_c = wdata_q;
      end

      case (state_q)
         ST_IDLE: begin
            if (req_c) begin
               idx_d   = mem_address[ADDR_WIDTH-1:1];
               op_d    = mem_write ? mop_write : mop_read;
               mask_d  = mem_byte_enable;
               wdata_d = mem_wdata;
               if (mem_read && mem_write) err_d = 1'b1;
               if ((mem_write ? WR_WAIT : RD_WAIT) == '0) begin
                  state_d  = ST_RESP;
                  commit_c = 1'b1;
               end else begin
                  state_d = ST_WAIT;
                  cnt_d   = mem_write ? WR_WAIT : RD_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (!req_c) begin
               // Master withdrew the request: abandon it without touching RAM.
               state_d = ST_IDLE;
               cnt_d   = '0;
               err_d   = 1'b1;
            end else if (cnt_q == CNT_W'(1)) begin
               state_d  = ST_RESP;
               cnt_d    = '0;
               commit_c = 1'b1;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_RESP: state_d = ST_TURN;
         ST_TURN: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      ram_we_c = (commit_c && cmt_op_c == mop_write) ? cmt_mask_c : 2'b00;
      ram_re_c = commit_c && (cmt_op_c == mop_read);
      resp_d   = commit_c;
   end

   // State, capture and flag registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         op_q    <= mop_read;
         mask_q  <= '0;
         wdata_q <= '0;
         resp_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         op_q    <= op_d;
         mask_q  <= mask_d;
         wdata_q <= wdata_d;
         resp_q  <= resp_d;
         err_q   <= err_d;
      end
   end

   byte_en_ram #(
      .IDX_WIDTH (IDX_W),
      .INIT_FILE (INIT_FILE)
   ) u_ram (
      .clk     (clk),
      .rst     (rst),
      .idx_i   (ram_idx_c),
      .we_i    (ram_we_c),
      .re_i    (ram_re_c),
      .wdata_i (ram_wdata_c),
      .rdata_o (mem_rdata)
   );

   assign mem_resp  = resp_q;
   assign proto_err = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: a two-wait-state instance (s_*) and a zero-wait
// instance (f_*) share clock and reset; read data is checked against a
// scoreboard fed from a bench-side memory model.
module tb_mem_responder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [15:0] s_addr, s_wdata, s_rdata, f_addr, f_wdata, f_rdata;
   logic        s_rd, s_wr, s_resp, s_err, f_rd, f_wr, f_resp, f_err;
   logic [1:0]  s_be, f_be;

   int errors = 0;
   int checks = 0;

   logic [15:0] exp_q [$];
   logic [15:0] mdl_s [int];
   logic [15:0] mdl_f [int];

   mem_responder #(.ADDR_WIDTH(16), .READ_WAIT(2), .WRITE_WAIT(2)) u_slow (
      .clk(clk), .rst(rst), .mem_address(s_addr), .mem_read(s_rd), .mem_write(s_wr),
      .mem_byte_enable(s_be), .mem_wdata(s_wdata), .mem_rdata(s_rdata),
      .mem_resp(s_resp), .proto_err(s_err));

   mem_responder #(.ADDR_WIDTH(16), .READ_WAIT(0), .WRITE_WAIT(0)) u_fast (
      .clk(clk), .rst(rst), .mem_address(f_addr), .mem_read(f_rd), .mem_write(f_wr),
      .mem_byte_enable(f_be), .mem_wdata(f_wdata), .mem_rdata(f_rdata),
      .mem_resp(f_resp), .proto_err(f_err));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input bit fast, input bit rd, input bit wr,
                        input logic [15:0] addr, input logic [1:0] be, input logic [15:0] wd);
      if (fast) begin f_rd = rd; f_wr = wr; f_addr = addr; f_be = be; f_wdata = wd; end
      else      begin s_rd = rd; s_wr = wr; s_addr = addr; s_be = be; s_wdata = wd; end
   endtask

   // One complete transaction starting in an idle cycle; returns in the next idle cycle.
   task automatic txn(input bit fast, input bit rd, input bit wr, input logic [15:0] addr,
                      input logic [1:0] be, input logic [15:0] wd, input string tag);
      int          lat;
      int          seen;
      int          idx;
      logic [15:0] w;
      logic [15:0] e;
      lat = fast ? 1 : 3;
      idx = int'(addr[15:1]);
      if (wr) begin
         w = fast ? (mdl_f.exists(idx) ? mdl_f[idx] : 16'h0000)
                  : (mdl_s.exists(idx) ? mdl_s[idx] : 16'h0000);
         if (be[0]) w[7:0]  = wd[7:0];
         if (be[1]) w[15:8] = wd[15:8];
         if (fast) mdl_f[idx] = w; else mdl_s[idx] = w;
      end else if (rd) begin
         exp_q.push_back(fast ? mdl_f[idx] : mdl_s[idx]);
      end
      drive(fast, rd, wr, addr, be, wd);
      seen = 0;
      for (int n = 1; n <= lat + 2 && seen == 0; n++) begin
         @(posedge clk); #1;
         if ((fast ? f_resp : s_resp) === 1'b1) seen = n;
      end
      drive(fast, 1'b0, 1'b0, addr, be, wd);
      check($sformatf("%s latency", tag), 32'(seen), 32'(lat));
      if (rd && !wr && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check($sformatf("%s rdata", tag), 32'(fast ? f_rdata : s_rdata), 32'(e));
      end
      @(posedge clk); #1;
      check($sformatf("%s single pulse", tag), 32'(fast ? f_resp : s_resp), 32'(0));
      @(posedge clk); #1;
   endtask

   initial begin
      int cnt;
      rst = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 16'h0, 2'b00, 16'h0);
      drive(1'b1, 1'b0, 1'b0, 16'h0, 2'b00, 16'h0);

      // Async reset before any clock edge.
      #2 rst = 1'b1;
      #1;
      check("rst s_resp", 32'(s_resp), 32'(0));
      check("rst s_rdata", 32'(s_rdata), 32'(0));
      check("rst s_err", 32'(s_err), 32'(0));
      check("rst f_resp", 32'(f_resp), 32'(0));
      @(posedge clk); @(negedge clk) rst = 1'b0;
      @(posedge clk); #1;

      // Word read and byte-lane writes, two wait states.
      txn(1'b0, 1'b0, 1'b1, 16'h3000, 2'b11, 16'h1234, "s_init3000");
      txn(1'b0, 1'b1, 1'b0, 16'h3000, 2'b11, 16'h0000, "s_rd1234");
      txn(1'b0, 1'b0, 1'b1, 16'h3001, 2'b01, 16'h00AB, "s_wr_lo");
      txn(1'b0, 1'b1, 1'b0, 16'h3000, 2'b00, 16'h0000, "s_rd12AB");
      txn(1'b0, 1'b0, 1'b1, 16'h3000, 2'b10, 16'hCD00, "s_wr_hi");
      txn(1'b0, 1'b1, 1'b0, 16'h3001, 2'b00, 16'h0000, "s_rdCDAB");
      txn(1'b0, 1'b0, 1'b1, 16'h3000, 2'b00, 16'hFFFF, "s_wr_none");
      txn(1'b0, 1'b1, 1'b0, 16'h3000, 2'b00, 16'h0000, "s_rd_unch");
      check("s_err clean", 32'(s_err), 32'(0));

      // Zero-wait instance: back-to-back single-cycle responses.
      txn(1'b1, 1'b0, 1'b1, 16'h0000, 2'b11, 16'hA001, "f_wr0");
      txn(1'b1, 1'b0, 1'b1, 16'h0002, 2'b11, 16'hB002, "f_wr2");
      txn(1'b1, 1'b0, 1'b1, 16'h0004, 2'b11, 16'hC003, "f_wr4");
      txn(1'b1, 1'b1, 1'b0, 16'h0000, 2'b00, 16'h0000, "f_rd0");
      txn(1'b1, 1'b1, 1'b0, 16'h0002, 2'b00, 16'h0000, "f_rd2");
      txn(1'b1, 1'b1, 1'b0, 16'h0004, 2'b00, 16'h0000, "f_rd4");
      check("f_err clean", 32'(f_err), 32'(0));

      // Read and write together: the write wins and the flag sets.
      txn(1'b0, 1'b1, 1'b1, 16'h0010, 2'b11, 16'hBEEF, "s_both");
      check("s_err both", 32'(s_err), 32'(1));
      txn(1'b0, 1'b1, 1'b0, 16'h0010, 2'b00, 16'h0000, "s_rdBEEF");

      // Mid-cycle reset clears the sticky flag and read data asynchronously.
      #2 rst = 1'b1;
      #1;
      check("rst2 s_err", 32'(s_err), 32'(0));
      check("rst2 s_rdata", 32'(s_rdata), 32'(0));
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1;

      // Write withdrawn during WAIT.
      txn(1'b0, 1'b0, 1'b1, 16'h0040, 2'b11, 16'h1111, "s_wr40");
      drive(1'b0, 1'b0, 1'b1, 16'h0040, 2'b11, 16'h2222);
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 1'b0, 16'h0040, 2'b11, 16'h2222);
      cnt = 0;
      for (int n = 0; n < 5; n++) begin
         @(posedge clk); #1;
         if (s_resp === 1'b1) cnt++;
      end
      check("drop no resp", 32'(cnt), 32'(0));
      check("drop s_err", 32'(s_err), 32'(1));
      txn(1'b0, 1'b1, 1'b0, 16'h0040, 2'b00, 16'h0000, "s_rd_after_drop");

      // Reset during WAIT of a write discards it.
      txn(1'b0, 1'b0, 1'b1, 16'h0020, 2'b11, 16'h5555, "s_wr20");
      drive(1'b0, 1'b0, 1'b1, 16'h0020, 2'b11, 16'hAAAA);
      @(posedge clk); #1;
      #1 rst = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 16'h0020, 2'b11, 16'hAAAA);
      #1;
      check("rstwait s_resp", 32'(s_resp), 32'(0));
      @(negedge clk) rst = 1'b0;
      cnt = 0;
      for (int n = 0; n < 4; n++) begin
         @(posedge clk); #1;
         if (s_resp === 1'b1) cnt++;
      end
      check("rstwait no resp", 32'(cnt), 32'(0));
      check("rstwait s_err", 32'(s_err), 32'(0));
      txn(1'b0, 1'b1, 1'b0, 16'h0020, 2'b00, 16'h0000, "s_rd5555");

      // Reset in the RESP cycle drops mem_resp without waiting for a clock.
      drive(1'b0, 1'b1, 1'b0, 16'h0020, 2'b00, 16'h0000);
      cnt = 0;
      for (int n = 1; n <= 5 && cnt == 0; n++) begin
         @(posedge clk); #1;
         if (s_resp === 1'b1) cnt = n;
      end
      check("resp before reset", 32'(cnt), 32'(3));
      check("resp before reset rdata", 32'(s_rdata), 32'(16'h5555));
      rst = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 16'h0020, 2'b00, 16'h0000);
      #1;
      check("rstresp s_resp", 32'(s_resp), 32'(0));
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
